// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and the elaboration-time binary-to-BCD helper
// used by the up/down counter and its per-digit step cells.
package bcd_pkg;

    localparam int MAX_DIGITS = 4;

    typedef logic [3:0]              bcd_digit_t;
    typedef logic [4*MAX_DIGITS-1:0] bcd_word_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Only ever evaluated on parameters, so the division never reaches hardware.
    function automatic bcd_word_t to_bcd(input int value, input int digits);
        bcd_word_t res;
        int        v;
        res = '0;
        v   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                res[4*i +: 4] = 4'(v % 10);
                v             = v / 10;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the increment/decrement ripple chain. A digit steps only
// when its carry-in (inc) or borrow-in (dec) enable is present.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       inc,
    input  logic       dec,
    input  logic       cin,
    input  logic       bin,
    output bcd_digit_t next_digit,
    output logic       cout,
    output logic       bout
);

    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        bout       = 1'b0;
        if (inc && cin) begin
            if (digit == BCD_NINE) begin
                next_digit = BCD_ZERO;
                cout       = 1'b1;
            end else begin
                next_digit = digit + 4'd1;
            end
        end else if (dec && bin) begin
            if (digit == BCD_ZERO) begin
                next_digit = BCD_NINE;
                bout       = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter_m.sv
// Packed-BCD up/down counter with programmable modulus, clear, checked parallel
// load and wrap-or-saturate ends; co/bo pulses cascade into the next stage.
module bcd_updown_counter_m
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60,
    parameter bit WRAP    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                up,
    input  logic                dn,
    output logic [4*DIGITS-1:0] count,
    output logic                co,
    output logic                bo,
    output logic                at_max,
    output logic                at_zero,
    output logic                load_err
);

    localparam int        W            = 4*DIGITS;
    localparam int        MOD_LIMIT    = 10**DIGITS;
    localparam bcd_word_t MAX_BCD_FULL = to_bcd(MODULUS-1, DIGITS);
    localparam logic [W-1:0] MAX_BCD   = MAX_BCD_FULL[W-1:0];

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_updown_counter_m: DIGITS=%0d outside 1..%0d", DIGITS, MAX_DIGITS);
    end
    if (MODULUS < 2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
        $error("bcd_updown_counter_m: MODULUS=%0d outside 2..%0d", MODULUS, MOD_LIMIT);
    end

    logic [W-1:0]    count_q, count_d;
    logic            co_q, co_d;
    logic            bo_q, bo_d;
    logic            err_q, err_d;

    logic            step_up, step_dn;
    logic [W-1:0]    stepped;
    logic [DIGITS:0] carry, borrow;
    logic            unused_chain_top;
    logic            load_ok;

    assign step_up   = up & ~dn;
    assign step_dn   = dn & ~up;
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (count_q[4*i +: 4]),
            .inc        (step_up),
            .dec        (step_dn),
            .cin        (carry[i]),
            .bin        (borrow[i]),
            .next_digit (stepped[4*i +: 4]),
            .cout       (carry[i+1]),
            .bout       (borrow[i+1])
        );
    end

    // Range ends are handled explicitly, so the chain never runs off the top digit.
    assign unused_chain_top = carry[DIGITS] ^ borrow[DIGITS];

    // With every digit <= 9, packed BCD orders exactly like its binary value.
    always_comb begin
        load_ok = (load_val <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > BCD_NINE) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        co_d    = 1'b0;
        bo_d    = 1'b0;
        err_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (step_up) begin
            if (count_q == MAX_BCD) begin
                if (WRAP) begin
                    count_d = '0;
                    co_d    = 1'b1;
                end
            end else begin
                count_d = stepped;
            end
        end else if (step_dn) begin
            if (count_q == '0) begin
                if (WRAP) begin
                    count_d = MAX_BCD;
                    bo_d    = 1'b1;
                end
            end else begin
                count_d = stepped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            co_q    <= 1'b0;
            bo_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            co_q    <= co_d;
            bo_q    <= bo_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign co       = co_q;
    assign bo       = bo_q;
    assign load_err = err_q;
    assign at_max   = (count_q == MAX_BCD);
    assign at_zero  = (count_q == '0);

endmodule

// File: tb/tb_bcd_updown_counter_m.sv
// Self-checking bench: mod-60 wrapping counter, 3-digit saturating counter and
// a seconds->minutes cascade, each compared against an integer reference model.
module tb_bcd_updown_counter_m;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    // ---------------- DUT A: 2 digits, mod 60, wrap ----------------
    logic       a_rst, a_clr, a_load, a_up, a_dn;
    logic [7:0] a_lv, a_count;
    logic       a_co, a_bo, a_max, a_zero, a_err;
    int         a_val;

    bcd_updown_counter_m #(.DIGITS(2), .MODULUS(60), .WRAP(1'b1)) u_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .load(a_load), .load_val(a_lv),
        .up(a_up), .dn(a_dn), .count(a_count), .co(a_co), .bo(a_bo),
        .at_max(a_max), .at_zero(a_zero), .load_err(a_err)
    );

    // ---------------- DUT B: 3 digits, mod 1000, saturate ----------------
    logic        b_rst, b_clr, b_load, b_up, b_dn;
    logic [11:0] b_lv, b_count;
    logic        b_co, b_bo, b_max, b_zero, b_err;
    int          b_val;

    bcd_updown_counter_m #(.DIGITS(3), .MODULUS(1000), .WRAP(1'b0)) u_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .load(b_load), .load_val(b_lv),
        .up(b_up), .dn(b_dn), .count(b_count), .co(b_co), .bo(b_bo),
        .at_max(b_max), .at_zero(b_zero), .load_err(b_err)
    );

    // ---------------- cascade: seconds -> minutes ----------------
    logic       c_rst, c_up;
    logic [7:0] s_count, m_count;
    logic       s_co, s_bo, s_max, s_zero, s_err;
    logic       m_co, m_bo, m_max, m_zero, m_err;
    int         s_val, m_val, m_co_seen;
    bit         carry_prev;

    bcd_updown_counter_m #(.DIGITS(2), .MODULUS(60), .WRAP(1'b1)) u_sec (
        .clk(clk), .rst(c_rst), .clr(1'b0), .load(1'b0), .load_val(8'h00),
        .up(c_up), .dn(1'b0), .count(s_count), .co(s_co), .bo(s_bo),
        .at_max(s_max), .at_zero(s_zero), .load_err(s_err)
    );

    bcd_updown_counter_m #(.DIGITS(2), .MODULUS(60), .WRAP(1'b1)) u_min (
        .clk(clk), .rst(c_rst), .clr(1'b0), .load(1'b0), .load_val(8'h00),
        .up(s_co), .dn(s_bo), .count(m_count), .co(m_co), .bo(m_bo),
        .at_max(m_max), .at_zero(m_zero), .load_err(m_err)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] enc(input int value, input int digits);
        logic [15:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic void decode(input logic [15:0] p, input int digits, input int modulus,
                                   output int v, output bit ok);
        int dg;
        v  = 0;
        ok = 1'b1;
        for (int i = digits - 1; i >= 0; i--) begin
            dg = int'(p[4*i +: 4]);
            if (dg > 9) ok = 1'b0;
            v = v * 10 + dg;
        end
        if (v >= modulus) ok = 1'b0;
    endfunction

    function automatic void model(input int modulus, input bit wrap,
                                  input bit r, input bit c, input bit l,
                                  input int lv, input bit lv_ok, input bit u, input bit d,
                                  inout int val, output bit co, output bit bo, output bit err);
        co  = 1'b0;
        bo  = 1'b0;
        err = 1'b0;
        if (r || c) begin
            val = 0;
        end else if (l) begin
            if (lv_ok) val = lv;
            else err = 1'b1;
        end else if (u && !d) begin
            if (val == modulus - 1) begin
                if (wrap) begin
                    val = 0;
                    co  = 1'b1;
                end
            end else begin
                val = val + 1;
            end
        end else if (d && !u) begin
            if (val == 0) begin
                if (wrap) begin
                    val = modulus - 1;
                    bo  = 1'b1;
                end
            end else begin
                val = val - 1;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic a_cycle(input bit r, input bit c, input bit l, input logic [7:0] lv,
                           input bit u, input bit d);
        int lvv;
        bit ok, eco, ebo, eerr;
        a_rst = r; a_clr = c; a_load = l; a_lv = lv; a_up = u; a_dn = d;
        @(posedge clk);
        #1;
        decode({8'h00, lv}, 2, 60, lvv, ok);
        model(60, 1'b1, r, c, l, lvv, ok, u, d, a_val, eco, ebo, eerr);
        exp_q.push_back(enc(a_val, 2));
        check("a_count", {8'h00, a_count}, exp_q.pop_front());
        check("a_co", {15'h0, a_co}, {15'h0, eco});
        check("a_bo", {15'h0, a_bo}, {15'h0, ebo});
        check("a_load_err", {15'h0, a_err}, {15'h0, eerr});
        check("a_at_max", {15'h0, a_max}, {15'h0, a_val == 59});
        check("a_at_zero", {15'h0, a_zero}, {15'h0, a_val == 0});
    endtask

    task automatic b_cycle(input bit r, input bit c, input bit l, input logic [11:0] lv,
                           input bit u, input bit d);
        int lvv;
        bit ok, eco, ebo, eerr;
        b_rst = r; b_clr = c; b_load = l; b_lv = lv; b_up = u; b_dn = d;
        @(posedge clk);
        #1;
        decode({4'h0, lv}, 3, 1000, lvv, ok);
        model(1000, 1'b0, r, c, l, lvv, ok, u, d, b_val, eco, ebo, eerr);
        exp_q.push_back(enc(b_val, 3));
        check("b_count", {4'h0, b_count}, exp_q.pop_front());
        check("b_co", {15'h0, b_co}, {15'h0, eco});
        check("b_bo", {15'h0, b_bo}, {15'h0, ebo});
        check("b_load_err", {15'h0, b_err}, {15'h0, eerr});
        check("b_at_max", {15'h0, b_max}, {15'h0, b_val == 999});
        check("b_at_zero", {15'h0, b_zero}, {15'h0, b_val == 0});
    endtask

    // Minutes see the seconds carry one cycle late, since co is registered.
    task automatic c_cycle(input bit u);
        bit e_mco, e_sco;
        c_up = u;
        @(posedge clk);
        #1;
        e_mco = carry_prev && (m_val == 59);
        if (carry_prev) m_val = (m_val + 1) % 60;
        e_sco = u && (s_val == 59);
        s_val = (s_val + int'(u)) % 60;
        carry_prev = e_sco;
        if (m_co === 1'b1) m_co_seen++;
        check("sec_count", {8'h00, s_count}, enc(s_val, 2));
        check("sec_co", {15'h0, s_co}, {15'h0, e_sco});
        check("min_count", {8'h00, m_count}, enc(m_val, 2));
        check("min_co", {15'h0, m_co}, {15'h0, e_mco});
    endtask

    function automatic logic [3:0] rnd_digit();
        return 4'($urandom_range(0, 11));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        a_rst = 1'b1; a_clr = 1'b0; a_load = 1'b0; a_lv = '0; a_up = 1'b0; a_dn = 1'b0;
        b_rst = 1'b1; b_clr = 1'b0; b_load = 1'b0; b_lv = '0; b_up = 1'b0; b_dn = 1'b0;
        c_rst = 1'b1; c_up = 1'b0;
        a_val = 0; b_val = 0; s_val = 0; m_val = 0; carry_prev = 1'b0; m_co_seen = 0;
        repeat (2) @(posedge clk);
        #1;

        // --- A: wrap at 59, borrow at 0, load checks, priorities ---
        a_cycle(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 60; i++) a_cycle(0, 0, 0, 8'h00, 1, 0);
        a_cycle(0, 0, 0, 8'h00, 0, 0);
        a_cycle(0, 0, 0, 8'h00, 0, 1);
        a_cycle(0, 0, 0, 8'h00, 0, 1);
        a_cycle(0, 0, 1, 8'h10, 0, 0);
        a_cycle(0, 0, 0, 8'h00, 0, 1);
        a_cycle(0, 0, 1, 8'h45, 0, 0);
        a_cycle(0, 0, 1, 8'h7A, 0, 0);
        a_cycle(0, 0, 1, 8'h60, 0, 0);
        a_cycle(0, 0, 0, 8'h00, 0, 0);
        a_cycle(0, 0, 1, 8'h12, 1, 0);
        a_cycle(0, 0, 1, 8'h23, 0, 0);
        a_cycle(0, 0, 0, 8'h00, 1, 1);
        a_cycle(0, 1, 1, 8'h45, 1, 0);
        a_cycle(0, 0, 1, 8'h37, 0, 0);
        a_cycle(1, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 400; i++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            a_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 7) == 0, {rnd_digit(), rnd_digit()},
                    mode == 0 || mode == 2, mode == 1 || mode == 2);
        end
        a_rst = 1'b0; a_clr = 1'b0; a_load = 1'b0; a_up = 1'b0; a_dn = 1'b0;

        // --- B: saturation at both ends, multi-digit ripple ---
        b_cycle(1, 0, 0, 12'h000, 0, 0);
        b_cycle(0, 0, 1, 12'h999, 0, 0);
        b_cycle(0, 0, 0, 12'h000, 1, 0);
        b_cycle(0, 0, 0, 12'h000, 1, 0);
        b_cycle(0, 0, 1, 12'h000, 0, 0);
        b_cycle(0, 0, 0, 12'h000, 0, 1);
        b_cycle(0, 0, 1, 12'h199, 0, 0);
        b_cycle(0, 0, 0, 12'h000, 1, 0);
        b_cycle(0, 0, 0, 12'h000, 0, 1);
        b_cycle(0, 0, 1, 12'h9A0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            b_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 7) == 0, {rnd_digit(), rnd_digit(), rnd_digit()},
                    mode == 0 || mode == 2, mode == 1 || mode == 2);
        end
        b_rst = 1'b0; b_clr = 1'b0; b_load = 1'b0; b_up = 1'b0; b_dn = 1'b0;

        // --- cascade: one hour of seconds ---
        c_rst = 1'b1;
        @(posedge clk);
        #1;
        check("cas_rst_sec", {8'h00, s_count}, 16'h0000);
        check("cas_rst_min", {8'h00, m_count}, 16'h0000);
        c_rst = 1'b0;
        for (int i = 0; i < 3600; i++) c_cycle(1'b1);
        c_cycle(1'b0);
        c_cycle(1'b0);
        check("cas_end_sec", {8'h00, s_count}, 16'h0000);
        check("cas_end_min", {8'h00, m_count}, 16'h0000);
        check("cas_min_co_count", 16'(m_co_seen), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter_m.md
Name: bcd_updown_counter_m

Overview:
- Parametrised packed-BCD up/down counter with programmable modulus, synchronous clear, parallel load and optional saturation.
- Successor to the fixed two-digit mod-60 up/down counter used in clock/timer display paths.
- Carry and borrow pulses cascade into the next stage (sec -> min -> hour). Packed BCD output feeds the seven-segment scan driver directly.

Parameters:
DIGITS, 2, number of BCD digits (1..4); count width is 4*DIGITS
MODULUS, 60, count range 0..MODULUS-1; 2 <= MODULUS <= 10**DIGITS
WRAP, 1, 1 = wrap at the range ends; 0 = saturate at 0 and MODULUS-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear to 0
load  in  1  parallel load strobe
load_val  in  4*DIGITS  packed BCD load value, digit 0 in bits [3:0]
up  in  1  count-up enable, one step per cycle while high
dn  in  1  count-down enable, one step per cycle while high
count  out  4*DIGITS  packed BCD count
co  out  1  carry pulse, one cycle
bo  out  1  borrow pulse, one cycle
at_max  out  1  combinational: count == MODULUS-1
at_zero  out  1  combinational: count == 0
load_err  out  1  one-cycle pulse: load was rejected

Behaviour:
- Reset is decided: one clock, clk; reset rst is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- On rst: count=0, co=0, bo=0, load_err=0. Reset wins over every other input, including when it arrives mid-count.
- Priority per cycle: rst > clr > load > (up XOR dn) > hold.
- Pulses: co, bo and load_err are registered. Each defaults to 0 every cycle and is asserted only in the cycle after the triggering edge.
- clr: count=0. No co/bo pulse.
- load, valid value: count=load_val. Valid means every digit is <= 9 and the binary value is < MODULUS.
- load, invalid value: count holds; load_err=1 for one cycle.
- up=dn=1: hold, no pulse.
- up only, count < MODULUS-1: BCD increment, with the digit carry rippling through all digits (e.g. 09 -> 10, 199 -> 200).
- up only, count == MODULUS-1:
  - WRAP=1: count=0, co=1.
  - WRAP=0: hold, co=0.
- dn only, count > 0: BCD decrement, with the digit borrow rippling (e.g. 10 -> 09, 200 -> 199).
- dn only, count == 0:
  - WRAP=1: count=MODULUS-1 in BCD, bo=1.
  - WRAP=0: hold, bo=0.
- Latency: one cycle from input edge to the count update. at_max and at_zero follow count combinationally.
- Sustained up or dn steps every cycle. Cascading is done by driving the next stage's up with co and its dn with bo.
- MODULUS = 10**DIGITS (e.g. 100 with 2 digits) must work: the wrap occurs at all-9s.
- The BCD constant for MODULUS-1 is computed at elaboration; no runtime division.
- Elaboration error if MODULUS or DIGITS is out of range.

Decomposition:
- Shared package bcd_pkg:
  - BCD digit type (4 bits).
  - Function to_bcd(int, digits) returning packed BCD.
  - Constants BCD_NINE and BCD_ZERO.
- Sub-module bcd_digit_step, combinational, one instance per digit:
  - Inputs: digit, inc, dec, cin/bin.
  - Outputs: next digit, cout, bout.
  - Digit 0 takes the step request; each higher digit takes the carry/borrow of the digit below.
- Top-level holds the state register, priority logic, range and load checks, and the pulse registers.

Test Plan:
- DIGITS=2, MODULUS=60: rst, then 60 cycles of up -> count reaches 0x59, next cycle 0x00 with co=1 for exactly one cycle; at_max high only at 0x59.
- From 0x00, a single dn -> count=0x59 and bo=1 one cycle; a further dn -> 0x58, bo=0; digit-borrow check 0x10 -> 0x09.
- load_val=0x45 -> count=0x45, load_err=0; load_val=0x7A or 0x60 -> count unchanged, load_err=1 one cycle; load together with up -> load wins.
- up=dn=1 at 0x23 -> count stays 0x23, no pulses; clr with load and up asserted -> count=0x00; rst mid-count at 0x37 -> 0x00 next cycle, all pulses 0.
- DIGITS=3, MODULUS=1000, WRAP=0: load 0x999, then up -> holds 0x999 with co=0; load 0x000, then dn -> holds with bo=0; 0x199 up -> 0x200.
- Two instances cascaded (MODULUS=60 seconds, co -> minutes up): 3600 up pulses -> both read 0x00; minutes co=1 exactly once.
